// File: rtl/feedback_pulser_pkg.sv
// Shared constants for the feedback pulser: FSM state encoding, default timing
// and a counter-width helper that never yields a zero-width vector.
package feedback_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ON   = 2'd1;
  localparam state_t GAP  = 2'd2;

  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_ON_MS    = 50;
  localparam int DEF_OFF_MS   = 50;
  localparam int DEF_PEND_W   = 3;

  // Bits needed to count 0..n-1, at least one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feedback_pulser_if.sv
// Trigger/status bundle between a controller (master) and the pulser (slave).
interface feedback_pulser_if
  import feedback_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
);
  logic              trig;
  logic              clear;
  logic              pulse_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output trig, clear, input pulse_out, busy, pending, overflow);
  modport slave  (input trig, clear, output pulse_out, busy, pending, overflow);
endinterface

// File: rtl/ms_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// i_restart holds the count at zero so the next period starts fresh.
module ms_tick_gen
  import feedback_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);
  localparam int            CW   = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/feedback_pulser.sv
// Turns single-cycle trigger events into ON_MS-long output pulses, each followed
// by an OFF_MS gap; triggers arriving while busy are queued in a saturating counter.
module feedback_pulser
  import feedback_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int ON_MS    = DEF_ON_MS,
  parameter int OFF_MS   = DEF_OFF_MS,
  parameter int PEND_W   = DEF_PEND_W
) (
  input logic               clk,
  input logic               reset_n,
  feedback_pulser_if.slave  bus
);
  localparam int TW = (cnt_w(ON_MS) > cnt_w(OFF_MS)) ? cnt_w(ON_MS) : cnt_w(OFF_MS);
  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_MS - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_MS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state, w_state_next;
  logic [TW-1:0]     r_tcnt, w_tcnt_next;
  logic [PEND_W-1:0] r_pend, w_pend_next;
  logic              r_pulse, r_busy, r_ovf;
  logic              w_ovf_next, w_enq, w_tick, w_restart;

  // Transitions out of ON/GAP always land on a prescaler wrap, so the count is
  // already zero there; only idling and aborts need an explicit restart.
  assign w_restart = (r_state == IDLE) || bus.clear;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt;
    w_pend_next  = r_pend;
    w_ovf_next   = 1'b0;
    w_enq        = 1'b0;
    if (bus.clear) begin
      w_state_next = IDLE;
      w_tcnt_next  = '0;
      w_pend_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.trig) w_state_next = ON;
        end
        ON: begin
          w_enq = bus.trig;
          if (w_tick) begin
            if (r_tcnt == ON_LAST) begin
              w_state_next = GAP;
              w_tcnt_next  = '0;
            end else begin
              w_tcnt_next = r_tcnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (w_tick && (r_tcnt == OFF_LAST)) begin
            w_tcnt_next = '0;
            // A trigger on the dequeue cycle replaces the entry being consumed.
            if (r_pend != '0) begin
              w_state_next = ON;
              if (!bus.trig) w_pend_next = r_pend - 1'b1;
            end else if (bus.trig) begin
              w_state_next = ON;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_enq = bus.trig;
            if (w_tick) w_tcnt_next = r_tcnt + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_tcnt_next  = '0;
          w_pend_next  = '0;
        end
      endcase
      if (w_enq) begin
        if (r_pend != PEND_MAX) w_pend_next = r_pend + 1'b1;
        else                    w_ovf_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tcnt  <= w_tcnt_next;
      r_pend  <= w_pend_next;
      r_ovf   <= w_ovf_next;
      r_pulse <= (w_state_next == ON);
      r_busy  <= (w_state_next != IDLE);
    end
  end

  assign bus.pulse_out = r_pulse;
  assign bus.busy      = r_busy;
  assign bus.pending   = r_pend;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_feedback_pulser.sv
// Directed bench for feedback_pulser: a cycle-countdown reference model is
// compared against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_feedback_pulser;
  localparam int TICK_DIV = 4;
  localparam int ON_MS    = 2;
  localparam int OFF_MS   = 1;
  localparam int PEND_W   = 2;
  localparam int ON_CYC   = ON_MS * TICK_DIV;
  localparam int GAP_CYC  = OFF_MS * TICK_DIV;
  localparam int PMAX     = (1 << PEND_W) - 1;
  localparam int P_IDLE = 0, P_ON = 1, P_GAP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  feedback_pulser_if #(.PEND_W(PEND_W)) bus ();

  feedback_pulser #(
    .TICK_DIV (TICK_DIV),
    .ON_MS    (ON_MS),
    .OFF_MS   (OFF_MS),
    .PEND_W   (PEND_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int test_id  = 0;

  // Reference model: phase plus cycles remaining in that phase.
  int m_ph   = P_IDLE;
  int m_rem  = 0;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  int rises[$];
  int high_cnt, ovf_cnt, ovf_cyc, max_pend, busy_fall;
  bit prev_pulse = 1'b0;
  bit prev_busy  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (test %0d, cycle %0d): got %0d, expected %0d", name, test_id, cyc - base, act, exp);
    end
  endtask

  task automatic model_enqueue();
    if (bus.trig) begin
      if (m_pend < PMAX) m_pend++;
      else               m_ovf = 1'b1;
    end
  endtask

  task automatic model_edge();
    m_ovf = 1'b0;
    if (!reset_n) begin
      m_ph = P_IDLE; m_rem = 0; m_pend = 0;
    end else if (bus.clear) begin
      m_ph = P_IDLE; m_rem = 0; m_pend = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (bus.trig) begin m_ph = P_ON; m_rem = ON_CYC; end
        P_ON: begin
          model_enqueue();
          m_rem--;
          if (m_rem == 0) begin m_ph = P_GAP; m_rem = GAP_CYC; end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_pend > 0) begin
              m_ph = P_ON; m_rem = ON_CYC;
              if (!bus.trig) m_pend--;
            end else if (bus.trig) begin
              m_ph = P_ON; m_rem = ON_CYC;
            end else begin
              m_ph = P_IDLE;
            end
          end else begin
            model_enqueue();
          end
        end
      endcase
    end
  endtask

  // One clock: model follows the edge, then DUT is compared and observed mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("pulse_out", 32'(bus.pulse_out), 32'(m_ph == P_ON));
    chk("busy",      32'(bus.busy),      32'(m_ph != P_IDLE));
    chk("pending",   32'(bus.pending),   32'(m_pend));
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    if (bus.pulse_out && !prev_pulse) begin
      rises.push_back(cyc - base);
      $display("test %0d: pulse rise at cycle %0d, pending %0d", test_id, cyc - base, bus.pending);
    end
    if (bus.pulse_out) high_cnt++;
    if (bus.overflow) begin ovf_cnt++; ovf_cyc = cyc - base; end
    if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
    if (!bus.busy && prev_busy) busy_fall = cyc - base;
    prev_pulse = bus.pulse_out;
    prev_busy  = bus.busy;
  endtask

  task automatic init_test(input int id);
    test_id   = id;
    base      = cyc;
    rises.delete();
    high_cnt  = 0;
    ovf_cnt   = 0;
    ovf_cyc   = -1;
    max_pend  = 0;
    busy_fall = -1;
  endtask

  task automatic run_to(input int c);
    while (cyc - base < c) step();
  endtask

  task automatic fire();
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
  endtask

  function automatic int rise_at(input int idx);
    return (rises.size() > idx) ? rises[idx] : -1;
  endfunction

  initial begin
    bus.trig  = 1'b0;
    bus.clear = 1'b0;
    #1;
    chk("reset_pulse_out", 32'(bus.pulse_out), 0);
    chk("reset_busy",      32'(bus.busy),      0);
    chk("reset_pending",   32'(bus.pending),   0);
    chk("reset_overflow",  32'(bus.overflow),  0);
    init_test(0);
    repeat (2) step();
    reset_n = 1'b1;

    // 1: single trigger
    init_test(1);
    run_to(10); fire(); run_to(30);
    chk("t1_rise_count", rises.size(), 1);
    chk("t1_rise_cycle", rise_at(0), 11);
    chk("t1_high_cycles", high_cnt, 8);
    chk("t1_busy_fall", busy_fall, 23);
    chk("t1_max_pending", max_pend, 0);

    // 2: queue fills, fifth trigger overflows
    init_test(2);
    run_to(10); fire();
    run_to(12); fire(); fire(); fire();
    chk("t2_pending_full", 32'(bus.pending), 3);
    fire();
    run_to(70);
    chk("t2_rise_count", rises.size(), 4);
    chk("t2_rise0", rise_at(0), 11);
    chk("t2_rise1", rise_at(1), 23);
    chk("t2_rise2", rise_at(2), 35);
    chk("t2_rise3", rise_at(3), 47);
    chk("t2_ovf_count", ovf_cnt, 1);
    chk("t2_ovf_cycle", ovf_cyc, 16);
    chk("t2_max_pending", max_pend, 3);
    chk("t2_busy_fall", busy_fall, 59);

    // 3: trigger on the final gap cycle is consumed directly
    init_test(3);
    run_to(10); fire();
    run_to(22); fire();
    run_to(50);
    chk("t3_rise_count", rises.size(), 2);
    chk("t3_rise1", rise_at(1), 23);
    chk("t3_max_pending", max_pend, 0);
    chk("t3_busy_fall", busy_fall, 35);

    // 4: clear with simultaneous trigger, mid-ON with two queued
    init_test(4);
    run_to(10); fire();
    run_to(12); fire(); fire();
    chk("t4_pending_before", 32'(bus.pending), 2);
    run_to(15);
    bus.clear = 1'b1; bus.trig = 1'b1;
    step();
    bus.clear = 1'b0; bus.trig = 1'b0;
    chk("t4_pulse_after_clear", 32'(bus.pulse_out), 0);
    chk("t4_busy_after_clear", 32'(bus.busy), 0);
    chk("t4_pending_after_clear", 32'(bus.pending), 0);
    run_to(50);
    chk("t4_rise_count", rises.size(), 1);
    chk("t4_ovf_count", ovf_cnt, 0);

    // 5: asynchronous reset mid-pulse
    init_test(5);
    run_to(10); fire();
    run_to(12); fire();
    run_to(14);
    #2 reset_n = 1'b0;
    m_ph = P_IDLE; m_rem = 0; m_pend = 0; m_ovf = 1'b0;
    #1;
    chk("t5_async_pulse_out", 32'(bus.pulse_out), 0);
    chk("t5_async_busy", 32'(bus.busy), 0);
    chk("t5_async_pending", 32'(bus.pending), 0);
    step(); step();
    reset_n = 1'b1;
    init_test(6);
    run_to(20); fire(); run_to(40);
    chk("t5_post_rise_count", rises.size(), 1);
    chk("t5_post_rise_cycle", rise_at(0), 21);
    chk("t5_post_high_cycles", high_cnt, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
